cb_exec: RTL and testbench
==========================

Name: cb_exec

Overview:
- Sequencer for the CB-prefixed instruction group. Takes the second opcode byte after 0xCB and fetches the operand from the register file or from memory at (HL).
- Drives the existing combinational cb_alu, then writes the result and flags back.
- Sits between the decoder (upstream) and the register file / memory bus (downstream). It is the sole consumer of cb_alu outputs.

Parameters:
ADDR_W, 16, memory address width
REG_HL, 3'd6, opcode[2:0] code selecting the (HL) memory operand

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  request; accepted only in IDLE
opcode  in  8  CB byte: [7:3] = cb_alu op, [2:0] = register index (B,C,D,E,H,L,(HL),A)
f_in  in  4  current flags {Z,N,H,C}
hl  in  ADDR_W  current HL value
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
rf_sel  out  3  register file read/write index
rf_rdata  in  8  combinational read data for rf_sel
rf_we  out  1  register write strobe
rf_wdata  out  8  register write data
f_we  out  1  flag write strobe
f_out  out  4  flag write data
mem_addr  out  ADDR_W  memory address
mem_rd  out  1  read request, held until mem_ack
mem_wr  out  1  write request, held until mem_ack
mem_wdata  out  8  write data
mem_rdata  in  8  read data, valid with mem_ack
mem_ack  in  1  memory handshake; may be high in the same cycle as the request

Behaviour:
- Clocking and reset: clk with rst synchronous and active-high. Reset forces IDLE and clears all outputs to 0 (busy, done, rf_we, f_we, mem_rd, mem_wr, rf_sel, rf_wdata, f_out, mem_addr, mem_wdata).
- Acceptance: start in IDLE latches opcode, f_in and hl into internal registers. start while busy is ignored, with no queueing.
- States: IDLE, FETCH, WB, MEM_WR.
- IDLE -> FETCH on accepted start.
- FETCH, register path (idx != REG_HL):
  - rf_sel = idx.
  - Latch rf_rdata at the clock edge, then go to WB.
- FETCH, memory path (idx == REG_HL):
  - mem_addr = latched hl, mem_rd = 1.
  - Stay until mem_ack; latch mem_rdata on the ack cycle, then go to WB.
  - mem_rd drops the cycle after ack.
- WB: the cb_alu inputs are the latched operand, latched op, and latched f_in.
  - BIT (op[4:3]=01): f_we=1, f_out=alu f; no data write; done=1 -> IDLE.
  - RES/SET (op[4]=1): f_we=0.
  - Rotate/shift/swap (op[4:3]=00): f_we=1, f_out=alu f.
  - Non-BIT, register path: rf_sel=idx, rf_we=1, rf_wdata=alu out, done=1 -> IDLE.
  - Non-BIT, memory path: go to MEM_WR. The flag write happens in WB.
- MEM_WR:
  - mem_wr=1, mem_addr=hl, mem_wdata=latched result, held stable until mem_ack.
  - On the ack cycle: done=1 -> IDLE.
- Latency, with zero-wait memory:
  - Register op: done 2 cycles after the start cycle.
  - BIT (HL): 2 cycles.
  - Other (HL) ops: 3 cycles.
  - Each wait cycle without mem_ack adds one cycle.
- Strobe rules:
  - rf_we, f_we and done are single-cycle pulses.
  - mem_rd and mem_wr are never high together.
  - No strobe is asserted outside WB/MEM_WR, except mem_rd in FETCH.
- Reset mid-operation (any state): abort with no further writes, even with a pending mem_ack.
- start coincident with rst: rst wins.
- Carry input: cb_alu sees the carry flag as sampled at start, not live f_in.

Decomposition:
- Shared package (gb_pkg):
  - State encoding (2-bit enum).
  - Flag bit positions FZ=3, FN=2, FH=1, FC=0.
  - Register index constants, with REG_HL=6 and REG_A=7.
  - CB op-group codes (ROT=2'b00, BIT=2'b01, RES=2'b10, SET=2'b11).
- One sub-module: the existing cb_alu, instantiated unchanged.
- No other hierarchy.

Test Plan:
- RLC B (opcode 0x00), B=0x85, f_in=0 -> rf_we with rf_sel=0, rf_wdata=0x0B; f_we, f_out=4'h1; done 2 cycles after start.
- RL C (0x11), C=0x80, f_in=0 -> rf_wdata=0x00, f_out=4'h9. Same op with f_in=4'h1 -> rf_wdata=0x01, f_out=4'h1.
- BIT 7,A (0x7F), A=0x7F, f_in=4'h1 -> f_out=4'hB; rf_we never asserted; done after 2 cycles.
- SWAP (HL) (0x36), hl=0xC000, mem returns 0xF0 with zero wait -> mem_wr addr 0xC000, data 0x0F; f_out=4'h0; done 3 cycles after start.
- SET 3,(HL) (0xDE), mem returns 0x00 after 3 wait cycles, write ack after 2 -> mem_wdata=0x08; f_we never asserted; mem_rd held 4 cycles, mem_wr held 3; done on the write-ack cycle.
- rst asserted during FETCH of a (HL) op with mem_ack high -> next cycle IDLE, all outputs 0, no mem_wr/rf_we/f_we. A start pulse during busy is ignored (exactly one done per accepted start).

Source files
------------

// File: rtl/gb_pkg.sv
// gb_pkg: shared types and constants for the CB-prefix execution path.
//   state_t        : cb_exec sequencer states
//   FZ/FN/FH/FC    : bit positions inside the {Z,N,H,C} flag nibble
//   REG_*          : register index codes carried in opcode[2:0]
//   OP_*           : CB op groups carried in opcode[7:6]
package gb_pkg;
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WB, S_MEM_WR} state_t;
   localparam int FZ = 3;
   localparam int FN = 2;
   localparam int FH = 1;
   localparam int FC = 0;
   localparam logic [2:0] REG_B  = 3'd0;
   localparam logic [2:0] REG_C  = 3'd1;
   localparam logic [2:0] REG_D  = 3'd2;
   localparam logic [2:0] REG_E  = 3'd3;
   localparam logic [2:0] REG_H  = 3'd4;
   localparam logic [2:0] REG_L  = 3'd5;
   localparam logic [2:0] REG_HL = 3'd6;
   localparam logic [2:0] REG_A  = 3'd7;
   localparam logic [1:0] OP_ROT = 2'b00;
   localparam logic [1:0] OP_BIT = 2'b01;
   localparam logic [1:0] OP_RES = 2'b10;
   localparam logic [1:0] OP_SET = 2'b11;
endpackage

// File: rtl/cb_alu.sv
// cb_alu: combinational CB-group ALU (rotates/shifts/swap, BIT, RES, SET).
//   op   : CB byte [7:3]; op[4:3] = group, op[2:0] = sub-op or bit number
//   a    : operand
//   f_in : incoming flags {Z,N,H,C}; C feeds RL/RR, BIT keeps it
//   res  : result byte (operand unchanged for BIT)
//   f    : resulting flags (f_in unchanged for RES/SET)
module cb_alu
   import gb_pkg::*;
(
   input  logic [4:0] op,
   input  logic [7:0] a,
   input  logic [3:0] f_in,
   output logic [7:0] res,
   output logic [3:0] f
);
   logic [7:0] r;
   logic       co;
   logic       c_in;
   assign c_in = f_in[FC];
   always_comb begin
      r  = a;
      co = 1'b0;
      case (op[2:0])
         3'd0:    begin r = {a[6:0], a[7]}; co = a[7]; end
         3'd1:    begin r = {a[0], a[7:1]}; co = a[0]; end
         3'd2:    begin r = {a[6:0], c_in}; co = a[7]; end
         3'd3:    begin r = {c_in, a[7:1]}; co = a[0]; end
         3'd4:    begin r = {a[6:0], 1'b0}; co = a[7]; end
         3'd5:    begin r = {a[7], a[7:1]}; co = a[0]; end
         3'd6:    begin r = {a[3:0], a[7:4]}; co = 1'b0; end
         default: begin r = {1'b0, a[7:1]}; co = a[0]; end
      endcase
      res = a;
      f   = f_in;
      case (op[4:3])
         OP_ROT:  begin res = r; f = {r == 8'h00, 1'b0, 1'b0, co}; end
         OP_BIT:  f = {~a[op[2:0]], 1'b0, 1'b1, c_in};
         OP_RES:  res = a & ~(8'h01 << op[2:0]);
         default: res = a | (8'h01 << op[2:0]);
      endcase
   end
endmodule

// File: rtl/cb_exec.sv
// cb_exec: sequencer for CB-prefixed ops; fetches the operand from the
// register file or (HL), runs cb_alu, writes result and flags back.
//   start/opcode/f_in/hl : request, latched only in IDLE
//   busy/done            : activity level and one-cycle completion pulse
//   rf_*                 : register file read index, write strobe and data
//   f_we/f_out           : flag write strobe and data {Z,N,H,C}
//   mem_*                : memory request/ack handshake at the latched HL
module cb_exec
   import gb_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        opcode,
   input  logic [3:0]        f_in,
   input  logic [ADDR_W-1:0] hl,
   output logic              busy,
   output logic              done,
   output logic [2:0]        rf_sel,
   input  logic [7:0]        rf_rdata,
   output logic              rf_we,
   output logic [7:0]        rf_wdata,
   output logic              f_we,
   output logic [3:0]        f_out,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_ack
);
   state_t            state_q, state_d;
   logic [4:0]        op_q;
   logic [2:0]        idx_q;
   logic [3:0]        f_q;
   logic [ADDR_W-1:0] hl_q;
   logic [7:0]        opnd_q;
   logic [7:0]        res_q;
   logic [7:0]        alu_res;
   logic [3:0]        alu_f;
   logic              is_mem;
   logic              is_bit;
   assign is_mem = idx_q == REG_HL;
   assign is_bit = op_q[4:3] == OP_BIT;
   assign busy   = state_q != S_IDLE;
   // Flags come from the start-time snapshot so a live f_in change cannot leak in.
   cb_alu u_alu (
      .op   (op_q),
      .a    (opnd_q),
      .f_in (f_q),
      .res  (alu_res),
      .f    (alu_f)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         idx_q   <= '0;
         f_q     <= '0;
         hl_q    <= '0;
         opnd_q  <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE && start) begin
            op_q  <= opcode[7:3];
            idx_q <= opcode[2:0];
            f_q   <= f_in;
            hl_q  <= hl;
         end
         if (state_q == S_FETCH && (!is_mem || mem_ack))
            opnd_q <= is_mem ? mem_rdata : rf_rdata;
         if (state_q == S_WB)
            res_q <= alu_res;
      end
   end
   always_comb begin
      state_d   = state_q;
      done      = 1'b0;
      rf_sel    = '0;
      rf_we     = 1'b0;
      rf_wdata  = '0;
      f_we      = 1'b0;
      f_out     = '0;
      mem_addr  = '0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      mem_wdata = '0;
      case (state_q)
         S_IDLE: state_d = start ? S_FETCH : S_IDLE;
         S_FETCH: begin
            rf_sel   = is_mem ? '0 : idx_q;
            mem_addr = is_mem ? hl_q : '0;
            mem_rd   = is_mem;
            state_d  = (!is_mem || mem_ack) ? S_WB : S_FETCH;
         end
         S_WB: begin
            // RES/SET leave flags untouched; BIT and rotate/shift groups write them.
            f_we     = !op_q[4];
            f_out    = op_q[4] ? '0 : alu_f;
            rf_we    = !is_bit && !is_mem;
            rf_sel   = rf_we ? idx_q : '0;
            rf_wdata = rf_we ? alu_res : '0;
            done     = is_bit || !is_mem;
            state_d  = done ? S_IDLE : S_MEM_WR;
         end
         default: begin
            mem_wr    = 1'b1;
            mem_addr  = hl_q;
            mem_wdata = res_q;
            done      = mem_ack;
            state_d   = mem_ack ? S_IDLE : S_MEM_WR;
         end
      endcase
   end
endmodule

// File: tb/tb_cb_exec.sv
// tb_cb_exec: directed table-driven bench for cb_exec with a register file
// model and a memory responder with programmable wait states.
module tb_cb_exec;
   logic        clk, rst, start, busy, done, rf_we, f_we, mem_rd, mem_wr, mem_ack;
   logic [7:0]  opcode, rf_rdata, rf_wdata, mem_wdata, mem_rdata;
   logic [3:0]  f_in, f_out;
   logic [15:0] hl, mem_addr;
   logic [2:0]  rf_sel;
   logic [7:0]  regs [8];
   int total, bad;
   int n_done, n_rfwe, n_fwe, n_rd, n_wr, overlap, done_cyc;
   logic [7:0]  s_wd, s_mwd;
   logic [3:0]  s_fo;
   logic [2:0]  s_sel;
   logic [15:0] s_rda, s_wra;
   typedef struct {
      logic [7:0] op;
      logic [7:0] v;
      logic [3:0] fi;
      logic [7:0] wd;
      logic [3:0] fo;
      int         rfwe;
      int         fwe;
   } vec_t;
   vec_t tv[8];
   cb_exec #(.ADDR_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .opcode(opcode), .f_in(f_in), .hl(hl),
      .busy(busy), .done(done), .rf_sel(rf_sel), .rf_rdata(rf_rdata), .rf_we(rf_we),
      .rf_wdata(rf_wdata), .f_we(f_we), .f_out(f_out), .mem_addr(mem_addr),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack)
   );
   assign rf_rdata = regs[rf_sel];
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask
   task automatic run_op(input logic [7:0] op, input logic [3:0] fi, input logic [15:0] h,
                         input logic [7:0] md, input int rw, input int ww, input bit bs);
      int cyc, rc, wc;
      n_done = 0; n_rfwe = 0; n_fwe = 0; n_rd = 0; n_wr = 0; overlap = 0; done_cyc = -1;
      rc = 0; wc = 0;
      @(negedge clk);
      start = 1'b1; opcode = op; f_in = fi; hl = h;
      @(negedge clk);
      start = 1'b0; opcode = ~op; f_in = ~fi; hl = ~h;
      cyc = 1;
      while (cyc < 50 && done_cyc < 0) begin
         start = bs && cyc == 1;
         mem_ack = 1'b0;
         if (mem_rd) begin
            if (rc == rw) begin mem_ack = 1'b1; mem_rdata = md; end
            else mem_rdata = 8'hEE;
            rc++; n_rd++; s_rda = mem_addr;
         end
         if (mem_wr) begin
            if (wc == ww) mem_ack = 1'b1;
            wc++; n_wr++; s_wra = mem_addr; s_mwd = mem_wdata;
         end
         #1;
         if (mem_rd && mem_wr) overlap++;
         if (rf_we) begin n_rfwe++; s_sel = rf_sel; s_wd = rf_wdata; end
         if (f_we) begin n_fwe++; s_fo = f_out; end
         if (done) begin n_done++; done_cyc = cyc; end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (done) n_done++;
         if (rf_we || f_we || mem_wr) overlap++;
         @(negedge clk);
      end
   endtask
   initial begin
      int stray;
      total = 0; bad = 0;
      rst = 1'b1; start = 1'b0; opcode = '0; f_in = '0; hl = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      for (int i = 0; i < 8; i++) regs[i] = 8'h5A;
      tv[0] = '{8'h00, 8'h85, 4'h0, 8'h0B, 4'h1, 1, 1};
      tv[1] = '{8'h11, 8'h80, 4'h0, 8'h00, 4'h9, 1, 1};
      tv[2] = '{8'h11, 8'h80, 4'h1, 8'h01, 4'h1, 1, 1};
      tv[3] = '{8'h7F, 8'h7F, 4'h1, 8'h00, 4'hB, 0, 1};
      tv[4] = '{8'h82, 8'hFF, 4'h0, 8'hFE, 4'h0, 1, 0};
      tv[5] = '{8'h2B, 8'h81, 4'h0, 8'hC0, 4'h1, 1, 1};
      tv[6] = '{8'h3C, 8'h01, 4'h0, 8'h00, 4'h9, 1, 1};
      tv[7] = '{8'h1D, 8'h01, 4'h1, 8'h80, 4'h1, 1, 1};
      repeat (3) @(negedge clk);
      #1;
      chk("reset_ctl", {busy, done, rf_we, f_we, mem_rd, mem_wr, rf_sel}, 64'h0);
      chk("reset_data", {rf_wdata, f_out, mem_addr, mem_wdata}, 64'h0);
      rst = 1'b0;
      foreach (tv[k]) begin
         for (int i = 0; i < 8; i++) regs[i] = 8'h5A;
         regs[tv[k].op[2:0]] = tv[k].v;
         run_op(tv[k].op, tv[k].fi, 16'h1234, 8'h00, 0, 0, 0);
         chk($sformatf("v%0d_latency", k), done_cyc, 2);
         chk($sformatf("v%0d_ndone", k), n_done, 1);
         chk($sformatf("v%0d_rfwe", k), n_rfwe, tv[k].rfwe);
         chk($sformatf("v%0d_fwe", k), n_fwe, tv[k].fwe);
         chk($sformatf("v%0d_mem", k), n_rd + n_wr + overlap, 0);
         if (tv[k].rfwe != 0) begin
            chk($sformatf("v%0d_sel", k), s_sel, tv[k].op[2:0]);
            chk($sformatf("v%0d_wdata", k), s_wd, tv[k].wd);
         end
         if (tv[k].fwe != 0) chk($sformatf("v%0d_fout", k), s_fo, tv[k].fo);
      end
      run_op(8'h36, 4'h0, 16'hC000, 8'hF0, 0, 0, 0);
      chk("swap_latency", done_cyc, 3);
      chk("swap_rd_addr", s_rda, 16'hC000);
      chk("swap_wr_addr", s_wra, 16'hC000);
      chk("swap_wdata", s_mwd, 8'h0F);
      chk("swap_fwe", n_fwe, 1);
      chk("swap_fout", s_fo, 4'h0);
      chk("swap_rfwe", n_rfwe, 0);
      chk("swap_rd_wr_cycles", {n_rd[7:0], n_wr[7:0], overlap[7:0]}, 64'h010100);
      run_op(8'hDE, 4'h0, 16'h8ABC, 8'h00, 3, 2, 0);
      chk("set_wdata", s_mwd, 8'h08);
      chk("set_fwe", n_fwe, 0);
      chk("set_rd_cycles", n_rd, 4);
      chk("set_wr_cycles", n_wr, 3);
      chk("set_latency", done_cyc, 8);
      chk("set_ndone", n_done, 1);
      chk("set_addr", {s_rda, s_wra}, {16'h8ABC, 16'h8ABC});
      chk("set_overlap", overlap, 0);
      run_op(8'h46, 4'h0, 16'h4000, 8'h01, 0, 0, 0);
      chk("bithl_latency", done_cyc, 2);
      chk("bithl_fout", s_fo, 4'h2);
      chk("bithl_wr", n_wr + n_rfwe, 0);
      regs[1] = 8'h80;
      run_op(8'h11, 4'h1, 16'h0, 8'h00, 0, 0, 1);
      chk("busy_start_ndone", n_done, 1);
      chk("busy_start_wdata", s_wd, 8'h01);
      @(negedge clk);
      start = 1'b1; opcode = 8'h36; hl = 16'hC000; f_in = 4'h0;
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("rst_fetch_rd", mem_rd, 1'b1);
      mem_ack = 1'b1; mem_rdata = 8'hF0; rst = 1'b1;
      @(negedge clk);
      #1;
      chk("rst_outputs", {busy, done, rf_we, f_we, mem_rd, mem_wr, mem_addr, mem_wdata}, 64'h0);
      rst = 1'b0; mem_ack = 1'b0;
      stray = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         if (busy || done || rf_we || f_we || mem_wr || mem_rd) stray++;
      end
      chk("rst_no_writes", stray, 0);
      @(negedge clk);
      rst = 1'b1; start = 1'b1; opcode = 8'h00;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      #1;
      chk("rst_beats_start", busy, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
